tdc_readout_fifo: RTL and testbench



---
 rtl/tdc_readout_fifo.sv | 137 +++++++++++++
 tb/tb_tdc_readout_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_readout_fifo.sv
// First-word-fall-through result FIFO between the TDC sequencer and the SPI decoder.
// Optional frame headers are compiled in with `define TDC_FIFO_HEADER_EN.
module tdc_readout_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  measuring,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  clear,
  input  logic                  rd,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [11:0]           frame_id
);

  localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  ovf_q, unf_q;
  logic                  push_req, push_ok, pop, drop;
  logic [DATA_W-1:0]     push_word;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_FULL);
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rd_data   = empty ? '0 : mem[rp];

  assign pop     = rd & ~empty;
  assign push_ok = push_req & (~full | pop);

`ifdef TDC_FIFO_HEADER_EN
  logic              meas_q, hdr_pend, hold_v, hold_v_d, hold_load, wr_drop;
  logic [DATA_W-1:0] hold_q;
  logic [11:0]       frame_q;

  // Header slot wins; a colliding wr is parked in the hold register, which
  // drains next cycle while a further wr takes its place behind it.
  always_comb begin
    push_req  = 1'b0;
    push_word = wr_data;
    hold_load = 1'b0;
    hold_v_d  = hold_v;
    wr_drop   = 1'b0;
    if (hdr_pend) begin
      push_req  = 1'b1;
      push_word = DATA_W'({4'hF, frame_q});
      if (wr) begin
        if (hold_v) begin
          wr_drop = 1'b1;
        end else begin
          hold_load = 1'b1;
          hold_v_d  = 1'b1;
        end
      end
    end else if (hold_v) begin
      push_req  = 1'b1;
      push_word = hold_q;
      hold_load = wr;
      hold_v_d  = wr;
    end else begin
      push_req = wr;
    end
  end

  assign drop     = wr_drop | (push_req & ~push_ok);
  assign frame_id = frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_q   <= 1'b0;
      hdr_pend <= 1'b0;
      hold_v   <= 1'b0;
      hold_q   <= '0;
      frame_q  <= '0;
    end else begin
      meas_q <= measuring;
      if (clear) begin
        hdr_pend <= 1'b0;
        hold_v   <= 1'b0;
        hold_q   <= '0;
      end else begin
        hdr_pend <= measuring & ~meas_q;
        hold_v   <= hold_v_d;
        if (hold_load) hold_q <= wr_data;
        if (hdr_pend)  frame_q <= frame_q + 12'd1;
      end
    end
  end
`else
  logic unused_meas;
  assign unused_meas = measuring;
  assign push_req    = wr;
  assign push_word   = wr_data;
  assign drop        = push_req & ~push_ok;
  assign frame_id    = '0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wp] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clear) begin
      wp      <= '0;
      rp      <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push_ok) level_q <= level_q - 1'b1;
      if (drop)        ovf_q <= 1'b1;
      if (rd && empty) unf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_readout_fifo.sv
// Directed bench for tdc_readout_fifo; header scenarios run when TDC_FIFO_HEADER_EN is defined.
module tb_tdc_readout_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        measuring;
  logic        wr;
  logic [15:0] wr_data;
  logic        clear;
  logic        rd;
  logic [15:0] rd_data;
  logic        empty, full, overflow, underflow;
  logic [6:0]  level;
  logic [11:0] frame_id;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_frame = 12'd0;

  tdc_readout_fifo #(.DATA_W(16), .DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .measuring(measuring), .wr(wr), .wr_data(wr_data),
    .clear(clear), .rd(rd), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .underflow(underflow), .frame_id(frame_id)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; measuring = 1'b0; wr = 1'b0; wr_data = '0; clear = 1'b0; rd = 1'b0;
    tick(); tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (level !== 7'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_sticky got %b%b exp 00", overflow, underflow); end
    tests++; if (frame_id !== 12'd0) begin fails++; $display("FAIL reset_frame got %0d exp 0", frame_id); end
    tests++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_push_pop;
    for (int i = 1; i <= 5; i++) begin
      wr = 1'b1; wr_data = 16'(i);
      tick();
      tests++; if (level !== 7'(i)) begin fails++; $display("FAIL push_level got %0d exp %0d", level, i); end
    end
    wr = 1'b0;
    tests++; if (rd_data !== 16'h0001) begin fails++; $display("FAIL fwft_head got %h exp 0001", rd_data); end
    rd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tests++; if (rd_data !== 16'(i)) begin fails++; $display("FAIL pop_order got %h exp %h", rd_data, 16'(i)); end
      tick();
    end
    rd = 1'b0;
    tests++; if (empty !== 1'b1 || level !== 7'd0) begin fails++; $display("FAIL pop_empty got empty=%b level=%0d exp 1/0", empty, level); end
    tests++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL empty_rd_data got %h exp 0000", rd_data); end
  endtask

  task automatic test_full_overflow;
    for (int i = 1; i <= 65; i++) begin
      wr = 1'b1; wr_data = 16'h0100 + 16'(i);
      tick();
      if (i == 63) begin
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL full_early got %b exp 0", full); end
      end
      if (i == 64) begin
        tests++; if (full !== 1'b1 || level !== 7'd64) begin fails++; $display("FAIL full_64 got full=%b level=%0d exp 1/64", full, level); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
    end
    wr = 1'b0;
    tests++; if (level !== 7'd64) begin fails++; $display("FAIL ovf_level got %0d exp 64", level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", overflow); end
    tests++; if (rd_data !== 16'h0101) begin fails++; $display("FAIL ovf_head got %h exp 0101", rd_data); end
  endtask

  task automatic test_full_push_pop;
    rd = 1'b1; wr = 1'b1; wr_data = 16'h1234;
    tick();
    wr = 1'b0; rd = 1'b0;
    tests++; if (level !== 7'd64 || full !== 1'b1) begin fails++; $display("FAIL full_rw_level got %0d full=%b exp 64/1", level, full); end
    rd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] exp_w;
      exp_w = (i < 63) ? 16'h0102 + 16'(i) : 16'h1234;
      tests++; if (rd_data !== exp_w) begin fails++; $display("FAIL full_rw_order idx %0d got %h exp %h", i, rd_data, exp_w); end
      tick();
    end
    rd = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_rw_drain got empty=%b exp 1", empty); end
  endtask

  task automatic test_underflow;
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL unf_early got %b exp 0", underflow); end
    rd = 1'b1;
    tick();
    tests++; if (underflow !== 1'b1 || level !== 7'd0) begin fails++; $display("FAIL unf_set got unf=%b level=%0d exp 1/0", underflow, level); end
    wr = 1'b1; wr_data = 16'h0055;
    tick();
    wr = 1'b0;
    tests++; if (level !== 7'd1 || rd_data !== 16'h0055) begin fails++; $display("FAIL unf_push got level=%0d data=%h exp 1/0055", level, rd_data); end
    tick();
    rd = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL unf_pop got empty=%b exp 1", empty); end
  endtask

`ifdef TDC_FIFO_HEADER_EN
  task automatic test_header;
    clear = 1'b1; tick(); clear = 1'b0;
    measuring = 1'b1;
    tick();
    tests++; if (level !== 7'd0) begin fails++; $display("FAIL hdr_latency got level=%0d exp 0", level); end
    wr = 1'b1; wr_data = 16'h00AA;
    tick();
    wr = 1'b0;
    exp_frame = 12'd1;
    tests++; if (frame_id !== exp_frame || rd_data !== 16'hF000) begin fails++; $display("FAIL hdr_push got frame=%0d data=%h exp 1/F000", frame_id, rd_data); end
    tick();
    tests++; if (level !== 7'd2) begin fails++; $display("FAIL hdr_hold got level=%0d exp 2", level); end
    rd = 1'b1;
    tests++; if (rd_data !== 16'hF000) begin fails++; $display("FAIL hdr_order0 got %h exp F000", rd_data); end
    tick();
    tests++; if (rd_data !== 16'h00AA) begin fails++; $display("FAIL hdr_order1 got %h exp 00AA", rd_data); end
    tick();
    rd = 1'b0;
  endtask

  task automatic test_back_to_back;
    measuring = 1'b0; tick();
    measuring = 1'b1; tick();
    wr = 1'b1; wr_data = 16'h00B1; tick();
    wr_data = 16'h00B2; tick();
    wr = 1'b0; tick();
    exp_frame = 12'd2;
    tests++; if (level !== 7'd3 || frame_id !== exp_frame) begin fails++; $display("FAIL b2b_level got level=%0d frame=%0d exp 3/2", level, frame_id); end
    rd = 1'b1;
    tests++; if (rd_data !== 16'hF001) begin fails++; $display("FAIL b2b_hdr got %h exp F001", rd_data); end
    tick();
    tests++; if (rd_data !== 16'h00B1) begin fails++; $display("FAIL b2b_w1 got %h exp 00B1", rd_data); end
    tick();
    tests++; if (rd_data !== 16'h00B2) begin fails++; $display("FAIL b2b_w2 got %h exp 00B2", rd_data); end
    tick();
    rd = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b exp 1", empty); end
  endtask
`endif

  task automatic test_clear;
    clear = 1'b1; tick(); clear = 1'b0;
    rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; wr_data = 16'h0200 + 16'(i); tick();
    end
    wr = 1'b0;
    tests++; if (level !== 7'd10 || underflow !== 1'b1) begin fails++; $display("FAIL clr_pre got level=%0d unf=%b exp 10/1", level, underflow); end
    clear = 1'b1; wr = 1'b1; wr_data = 16'h0BAD; rd = 1'b1;
    tick();
    clear = 1'b0; wr = 1'b0; rd = 1'b0;
    tests++; if (level !== 7'd0 || empty !== 1'b1) begin fails++; $display("FAIL clr_level got level=%0d empty=%b exp 0/1", level, empty); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL clr_sticky got %b%b exp 00", overflow, underflow); end
    tests++; if (frame_id !== exp_frame) begin fails++; $display("FAIL clr_frame got %0d exp %0d", frame_id, exp_frame); end
    wr = 1'b1; wr_data = 16'h0777; tick(); wr = 1'b0;
    tests++; if (rd_data !== 16'h0777 || level !== 7'd1) begin fails++; $display("FAIL clr_after got %h level=%0d exp 0777/1", rd_data, level); end
  endtask

  task automatic test_async_reset;
    rd = 1'b1; tick(); tick(); rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wr_data = 16'h0300 + 16'(i); tick();
    end
    tests++; if (level !== 7'd3 || underflow !== 1'b1) begin fails++; $display("FAIL arst_pre got level=%0d unf=%b exp 3/1", level, underflow); end
    #2 reset = 1'b1;
    #1;
    tests++; if (level !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL arst_level got level=%0d empty=%b full=%b exp 0/1/0", level, empty, full); end
    tests++; if (underflow !== 1'b0 || overflow !== 1'b0 || frame_id !== 12'd0) begin fails++; $display("FAIL arst_status got unf=%b ovf=%b frame=%0d exp 0/0/0", underflow, overflow, frame_id); end
    tests++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL arst_rd_data got %h exp 0000", rd_data); end
    wr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_full_push_pop();
    test_underflow();
`ifdef TDC_FIFO_HEADER_EN
    test_header();
    test_back_to_back();
`endif
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
